// File: rtl/prm_chk_pkg.sv
// Shared definitions for the PRM obstacle-check collector: code/bitmap widths,
// FSM state encoding and the mask fold helper.
package prm_chk_pkg;

  localparam int CODE_W      = 15;
  localparam int NUM_EDGE    = 64;
  localparam int MAX_CHK_LAT = 3;

  typedef logic [CODE_W-1:0]   obs_code_t;
  typedef logic [NUM_EDGE-1:0] edge_mask_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCAN  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // OR a checker-bank mask into the accumulator only when its tag qualifies it.
  function automatic edge_mask_t fold_mask(input edge_mask_t acc,
                                           input edge_mask_t mask,
                                           input logic       en);
    edge_mask_t res;
    if (en) begin
      res = acc | mask;
    end else begin
      res = acc;
    end
    return res;
  endfunction

endpackage

// File: rtl/prm_chk_delay_line.sv
// Tag/last shift register that aligns an accepted code with the checker-bank
// result. DEPTH = 0 degenerates to a plain wire.
module prm_chk_delay_line #(
  parameter int DEPTH = 1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic tag_i,
  input  logic last_i,
  output logic tag_o,
  output logic last_o
);

  if (DEPTH == 0) begin : g_wire
    // Clock and reset are not needed when the line has no storage.
    logic unused_clk_rst_s;
    assign unused_clk_rst_s = clk_i ^ rst_i;
    assign tag_o  = tag_i;
    assign last_o = last_i;
  end else begin : g_shift
    logic [DEPTH-1:0] tag_q;
    logic [DEPTH-1:0] last_q;

    // Shift tag and last marker one stage per cycle; reset empties the line.
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        tag_q  <= '0;
        last_q <= '0;
      end else begin
        tag_q[0]  <= tag_i;
        last_q[0] <= last_i & tag_i;
        for (int i = 1; i < DEPTH; i++) begin
          tag_q[i]  <= tag_q[i-1];
          last_q[i] <= last_q[i-1];
        end
      end
    end

    assign tag_o  = tag_q[DEPTH-1];
    assign last_o = last_q[DEPTH-1];
  end

endmodule

// File: rtl/prm_edge_block_collector.sv
// Initiator side of the PRM obstacle-check interface. Streams voxel codes to
// the edge-checker bank, ORs the returned edge masks into a per-scene blocked
// bitmap and hands bitmap plus saturating obstacle count to the planner.
module prm_edge_block_collector
  import prm_chk_pkg::*;
#(
  parameter int CHK_LAT = 1,   // checker-bank latency, 0..MAX_CHK_LAT
  parameter int CNT_W   = 16
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                obs_valid,
  output logic                obs_ready,
  input  logic [CODE_W-1:0]   obs_code,
  input  logic                obs_last,
  output logic [CODE_W-1:0]   chk_code,
  input  logic [NUM_EDGE-1:0] chk_mask,
  output logic                res_valid,
  input  logic                res_ready,
  output logic [NUM_EDGE-1:0] res_mask,
  output logic [CNT_W-1:0]    res_count,
  output logic                res_ovf
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1'b1);

  state_e            state_q;
  logic              obs_ready_q;
  logic [CODE_W-1:0] chk_code_q;
  logic              tag_q;
  logic              last_q;
  edge_mask_t        acc_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              ovf_q;
  logic              res_valid_q;

  logic              accept_s;
  logic              handshake_s;
  logic              dl_tag_s;
  logic              dl_last_s;
  logic              drained_s;
  edge_mask_t        acc_d;
  logic [CNT_W-1:0]  cnt_d;
  logic              ovf_d;

  // The tag/last pair is registered together with chk_code, so the delay line
  // only has to add the bank's own latency on top of that first stage.
  prm_chk_delay_line #(
    .DEPTH (CHK_LAT)
  ) u_delay_line (
    .clk_i  (CLK),
    .rst_i  (RST),
    .tag_i  (tag_q),
    .last_i (last_q),
    .tag_o  (dl_tag_s),
    .last_o (dl_last_s)
  );

  // Handshake qualifiers and the fold of the mask whose tag is leaving the line.
  always_comb begin
    accept_s    = obs_valid & obs_ready_q;
    handshake_s = res_valid_q & res_ready;
    drained_s   = dl_tag_s & dl_last_s;
    acc_d       = fold_mask(acc_q, chk_mask, dl_tag_s);
  end

  // Saturating obstacle counter; overflow flags a code that could not be counted.
  always_comb begin
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    if (accept_s) begin
      if (cnt_q == CNT_MAX) begin
        ovf_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_ONE;
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Scene FSM together with the code register, accumulator and output registers.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= ST_IDLE;
      obs_ready_q <= 1'b0;
      chk_code_q  <= '0;
      tag_q       <= 1'b0;
      last_q      <= 1'b0;
      acc_q       <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      res_valid_q <= 1'b0;
    end else begin
      tag_q  <= 1'b0;
      last_q <= 1'b0;
      acc_q  <= acc_d;
      case (state_q)
        ST_IDLE: begin
          state_q     <= ST_SCAN;
          obs_ready_q <= 1'b1;
        end
        ST_SCAN: begin
          if (accept_s) begin
            chk_code_q <= obs_code;
            tag_q      <= 1'b1;
            last_q     <= obs_last;
            cnt_q      <= cnt_d;
            ovf_q      <= ovf_d;
            if (obs_last) begin
              state_q     <= ST_DRAIN;
              obs_ready_q <= 1'b0;
            end else begin
              state_q     <= ST_SCAN;
              obs_ready_q <= 1'b1;
            end
          end else begin
            state_q     <= ST_SCAN;
            obs_ready_q <= 1'b1;
          end
        end
        ST_DRAIN: begin
          obs_ready_q <= 1'b0;
          if (drained_s) begin
            state_q     <= ST_DONE;
            res_valid_q <= 1'b1;
          end else begin
            state_q     <= ST_DRAIN;
            res_valid_q <= 1'b0;
          end
        end
        ST_DONE: begin
          if (handshake_s) begin
            state_q     <= ST_SCAN;
            obs_ready_q <= 1'b1;
            res_valid_q <= 1'b0;
            acc_q       <= '0;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
          end else begin
            state_q     <= ST_DONE;
            obs_ready_q <= 1'b0;
            res_valid_q <= 1'b1;
          end
        end
        default: begin
          state_q     <= ST_IDLE;
          obs_ready_q <= 1'b0;
          res_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign obs_ready = obs_ready_q;
  assign chk_code  = chk_code_q;
  assign res_valid = res_valid_q;
  assign res_mask  = acc_q;
  assign res_count = cnt_q;
  assign res_ovf   = ovf_q;

endmodule

// File: tb/tb_prm_edge_block_collector.sv
// Bench for prm_edge_block_collector: five instances (CHK_LAT 0..3 with a
// 16-bit counter, plus CHK_LAT 1 with a 4-bit counter) share one stimulus bus.
// Each has its own reference checker bank; a scoreboard queue holds the
// expected per-scene results.
module tb_prm_edge_block_collector;
  import prm_chk_pkg::*;

  localparam int NI = 5;

  typedef struct {
    int          n;
    int          gap;
    int          bp;
    logic [14:0] first;
    int          cnt16;
    int          cnt4;
    logic        ovf4;
  } scene_t;

  typedef struct {
    logic [63:0] mask;
    logic [14:0] last_code;
    int          cnt16;
    int          cnt4;
    logic        ovf4;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        obs_valid = 1'b0;
  logic        obs_last  = 1'b0;
  logic        res_ready = 1'b0;
  logic [14:0] obs_code  = 15'd0;

  logic        obs_ready_a [NI];
  logic [14:0] chk_code_a  [NI];
  logic [63:0] chk_mask_a  [NI];
  logic        res_valid_a [NI];
  logic [63:0] res_mask_a  [NI];
  logic [15:0] res_count_a [NI];
  logic        res_ovf_a   [NI];
  int          lat_a       [NI] = '{0, 1, 2, 3, 1};

  int          checks = 0;
  int          errors = 0;
  exp_t        sbq[$];
  logic [63:0] m_acc = 64'd0;
  logic [14:0] m_last = 15'd0;
  scene_t      tbl[8];

  always #5 clk = ~clk;

  // Reference truth table of the checker bank: each edge is blocked by two code fields.
  function automatic logic [63:0] model_mask(input logic [14:0] c);
    logic [63:0] m;
    m = 64'd0;
    for (int e = 0; e < 64; e++) begin
      m[e] = (c[5:0] == 6'(e)) || ({c[14:12], c[8:6]} == 6'(e));
    end
    return m;
  endfunction

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int LAT = (g == 4) ? 1 : g;
    localparam int CW  = (g == 4) ? 4 : 16;
    logic [CW-1:0] cnt_w;

    prm_edge_block_collector #(.CHK_LAT(LAT), .CNT_W(CW)) u_dut (
      .CLK       (clk),
      .RST       (rst),
      .obs_valid (obs_valid),
      .obs_ready (obs_ready_a[g]),
      .obs_code  (obs_code),
      .obs_last  (obs_last),
      .chk_code  (chk_code_a[g]),
      .chk_mask  (chk_mask_a[g]),
      .res_valid (res_valid_a[g]),
      .res_ready (res_ready),
      .res_mask  (res_mask_a[g]),
      .res_count (cnt_w),
      .res_ovf   (res_ovf_a[g])
    );
    assign res_count_a[g] = 16'(cnt_w);

    if (LAT == 0) begin : g_l0
      assign chk_mask_a[g] = model_mask(chk_code_a[g]);
    end else begin : g_lx
      logic [63:0] pipe_q [LAT];
      always @(posedge clk) begin
        pipe_q[0] <= model_mask(chk_code_a[g]);
        for (int j = 1; j < LAT; j++) pipe_q[j] <= pipe_q[j-1];
      end
      assign chk_mask_a[g] = pipe_q[LAT-1];
    end
  end

  task automatic chk(input string name, input int inst, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s[%0d] actual=%h required=%h at %0t", name, inst, act, expv, $time);
    end
  endtask

  // Asynchronous reset pulse: everything must read zero while RST is high.
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; obs_valid = 1'b0; obs_last = 1'b0; res_ready = 1'b0;
    #1;
    for (int i = 0; i < NI; i++) begin
      chk("rst_ready", i, 64'(obs_ready_a[i]), 64'd0);
      chk("rst_chk_code", i, 64'(chk_code_a[i]), 64'd0);
      chk("rst_res_valid", i, 64'(res_valid_a[i]), 64'd0);
      chk("rst_res_mask", i, res_mask_a[i], 64'd0);
      chk("rst_res_count", i, 64'(res_count_a[i]), 64'd0);
      chk("rst_res_ovf", i, 64'(res_ovf_a[i]), 64'd0);
    end
    m_acc = 64'd0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  // Drive one scene (optionally without obs_last); push expectations when it closes.
  task automatic send_scene(input scene_t s, input logic do_last);
    int          k;
    int          budget;
    logic        v;
    logic [14:0] c;
    k = 0;
    budget = 0;
    while (k < s.n) begin
      for (int i = 0; i < NI; i++) chk("scan_ready", i, 64'(obs_ready_a[i]), 64'd1);
      v = (s.gap == 0) || ($urandom_range(0, 99) >= s.gap);
      c = (k == 0) ? s.first : 15'($urandom);
      obs_valid = v; obs_code = c; obs_last = v && do_last && (k == s.n - 1);
      @(posedge clk);
      if (v) begin
        m_acc  = m_acc | model_mask(c);
        m_last = c;
        k++;
      end
      @(negedge clk);
      budget++;
      if (budget > 5000) begin
        chk("scene_budget", 0, 64'(k), 64'(s.n));
        break;
      end
    end
    obs_valid = 1'b0; obs_last = 1'b0;
    if (do_last) begin
      sbq.push_back('{m_acc, m_last, s.cnt16, s.cnt4, s.ovf4});
      m_acc = 64'd0;
    end
  endtask

  // Check result latency per instance, hold under backpressure, then hand off.
  task automatic collect(input logic next_v, input logic [14:0] next_code, input int bp);
    exp_t e;
    if (sbq.size() == 0) begin
      chk("sb_empty", 0, 64'd0, 64'd1);
      return;
    end
    e = sbq.pop_front();
    for (int cyc = 1; cyc <= 5; cyc++) begin
      for (int i = 0; i < NI; i++) begin
        chk("res_valid_lat", i, 64'(res_valid_a[i]), 64'(cyc >= lat_a[i] + 2));
        chk("drain_ready", i, 64'(obs_ready_a[i]), 64'd0);
        if (cyc == 1) chk("chk_code", i, 64'(chk_code_a[i]), 64'(e.last_code));
      end
      if (cyc < 5) @(negedge clk);
    end
    obs_valid = next_v; obs_code = next_code;
    for (int b = 0; b <= bp; b++) begin
      for (int i = 0; i < NI; i++) begin
        chk("res_mask", i, res_mask_a[i], e.mask);
        chk("res_count", i, 64'(res_count_a[i]), (i == 4) ? 64'(e.cnt4) : 64'(e.cnt16));
        chk("res_ovf", i, 64'(res_ovf_a[i]), (i == 4) ? 64'(e.ovf4) : 64'd0);
        chk("done_valid", i, 64'(res_valid_a[i]), 64'd1);
        chk("done_ready", i, 64'(obs_ready_a[i]), 64'd0);
        chk("hold_chk_code", i, 64'(chk_code_a[i]), 64'(e.last_code));
      end
      if (b < bp) @(negedge clk);
    end
    res_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    res_ready = 1'b0;
    for (int i = 0; i < NI; i++) begin
      chk("post_hs_valid", i, 64'(res_valid_a[i]), 64'd0);
      chk("post_hs_ready", i, 64'(obs_ready_a[i]), 64'd1);
      chk("post_hs_count", i, 64'(res_count_a[i]), 64'd0);
    end
  endtask

  initial begin
    scene_t part;
    //         n    gap bp  first      cnt16 cnt4 ovf4
    tbl[0] = '{2,   0,  0,  15'h0F0F,  2,    2,   1'b0};
    tbl[1] = '{1,   0,  0,  15'h7FC0,  1,    1,   1'b0};
    tbl[2] = '{100, 0,  0,  15'h1111,  100,  15,  1'b1};
    tbl[3] = '{4,   0,  20, 15'h1234,  4,    4,   1'b0};
    tbl[4] = '{20,  0,  0,  15'h0ABC,  20,   15,  1'b1};
    tbl[5] = '{7,   50, 3,  15'h5555,  7,    7,   1'b0};
    tbl[6] = '{16,  50, 0,  15'h2AAA,  16,   15,  1'b1};
    tbl[7] = '{12,  50, 1,  15'h0001,  12,   12,  1'b0};
    part   = '{5,   0,  0,  15'h3F3F,  0,    0,   1'b0};

    do_reset();
    // Reset mid-scene: three codes in flight, then RST; that scene must vanish.
    part.n = 3;
    send_scene(part, 1'b0);
    do_reset();

    for (int s = 0; s < 8; s++) begin
      send_scene(tbl[s], 1'b1);
      if (s < 7) collect(1'b1, tbl[s+1].first, tbl[s].bp);
      else       collect(1'b0, 15'd0, tbl[s].bp);
    end

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
